// File: rtl/vram_arbiter_if.sv
// Bundle of pixel timing, writer, clear and tile-RAM signals shared by the
// VRAM arbiter (slave side) and whatever surrounds it (master side).
interface vram_arbiter_if #(
    parameter int ADDR_W = 9
);
    logic              p_tick;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              wr_ack;
    logic              clr_req;
    logic [3:0]        clr_value;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_wdata;
    logic [3:0]        mem_rdata;
    logic [3:0]        tile_code;

    modport master (
        output p_tick, pixel_x, pixel_y, wr_req, wr_addr, wr_data,
               clr_req, clr_value, mem_rdata,
        input  wr_ack, clr_busy, mem_addr, mem_we, mem_wdata, tile_code
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, wr_req, wr_addr, wr_data,
               clr_req, clr_value, mem_rdata,
        output wr_ack, clr_busy, mem_addr, mem_we, mem_wdata, tile_code
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port tile RAM between the display prefetcher, a vblank
// map-clear engine and the game-logic writer, in that priority order.
module vram_arbiter #(
    parameter int TILE_COLS = 20,
    parameter int TILE_ROWS = 15,
    parameter int ADDR_W    = 9
) (
    input logic           clock_50,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    localparam int                TILE_COUNT = TILE_COLS * TILE_ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TILE_COUNT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VB, CLEAR} clr_state_t;

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
    logic [3:0]        clr_val, clr_val_next;
    logic [3:0]        next_tile;
    logic [3:0]        tile_q;
    logic              fetch_d;

    logic [9:0]        next_y;
    logic              in_vblank;
    logic              line_fetch, eol_fetch, fetch;
    int                fetch_row, fetch_col;
    logic              clr_write, wr_grant, wr_in_range, tile_load;
    logic [ADDR_W-1:0] addr_c;
    logic              we_c, ack_c;
    logic [3:0]        wdata_c;

    // A tile is prefetched two pixels before it is needed; the end-of-line
    // slot fetches column 0 of the following line instead.
    always_comb begin
        next_y     = (bus.pixel_y == 10'd524) ? 10'd0 : bus.pixel_y + 10'd1;
        in_vblank  = bus.pixel_y >= 10'd480;
        line_fetch = bus.p_tick && (bus.pixel_x < 10'd640) && (bus.pixel_x[4:0] == 5'd30)
                     && (int'(bus.pixel_x[9:5]) + 1 < TILE_COLS);
        eol_fetch  = bus.p_tick && (bus.pixel_x == 10'd798) && (next_y < 10'd480);
        fetch      = line_fetch || eol_fetch;
        fetch_row  = line_fetch ? int'(bus.pixel_y[9:5]) : int'(next_y[9:5]);
        fetch_col  = line_fetch ? int'(bus.pixel_x[9:5]) + 1 : 0;
        tile_load  = bus.p_tick && (((bus.pixel_x[4:0] == 5'd31) && (bus.pixel_x < 10'd639))
                     || (bus.pixel_x == 10'd799));
        clr_write   = (state == CLEAR) && in_vblank && !fetch;
        wr_grant    = bus.wr_req && !fetch && (state != CLEAR);
        wr_in_range = int'(bus.wr_addr) < TILE_COUNT;
    end

    // RAM port mux; out-of-range writer requests are acked but never reach the RAM.
    always_comb begin
        addr_c  = '0;
        we_c    = 1'b0;
        wdata_c = '0;
        ack_c   = 1'b0;
        if (!reset) begin
            if (fetch) begin
                addr_c = ADDR_W'(fetch_row * TILE_COLS + fetch_col);
            end else if (clr_write) begin
                addr_c  = clr_ptr;
                we_c    = 1'b1;
                wdata_c = clr_val;
            end else if (wr_grant) begin
                ack_c = 1'b1;
                if (wr_in_range) begin
                    addr_c  = bus.wr_addr;
                    we_c    = 1'b1;
                    wdata_c = bus.wr_data;
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        clr_val_next = clr_val;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    clr_val_next = bus.clr_value;
                    clr_ptr_next = '0;
                    state_next   = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (in_vblank) state_next = CLEAR;
            end
            CLEAR: begin
                if (!in_vblank) begin
                    state_next = WAIT_VB;
                end else if (!fetch) begin
                    clr_ptr_next = clr_ptr + ADDR_W'(1);
                    if (clr_ptr == LAST_ADDR) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data arrives one clock after a fetch and waits in next_tile until
    // the pixel pipeline crosses into the new tile.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state     <= IDLE;
            clr_ptr   <= '0;
            clr_val   <= '0;
            fetch_d   <= 1'b0;
            next_tile <= '0;
            tile_q    <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
            clr_val <= clr_val_next;
            fetch_d <= fetch;
            if (fetch_d) next_tile <= bus.mem_rdata;
            if (tile_load) tile_q <= next_tile;
        end
    end

    assign bus.mem_addr  = addr_c;
    assign bus.mem_we    = we_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.wr_ack    = ack_c;
    assign bus.clr_busy  = (state != IDLE);
    assign bus.tile_code = tile_q;
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: TILE_COLS, default 20, tiles per row; TILE_ROWS, default 15, tile rows; ADDR_W, default 9, tile RAM address width.
REQ-002 SHALL have ports:
- clock_50  in  1  system clock, 50 MHz; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- p_tick  in  1  pixel tick from the sync generator; 1 on every other clock.
- pixel_x  in  10  horizontal counter, 0..799.
- pixel_y  in  10  vertical counter, 0..524.
- wr_req  in  1  game-logic write request; held until acked.
- wr_addr  in  9  write address, 0..299.
- wr_data  in  4  tile code to write.
- wr_ack  out  1  one-cycle pulse; write performed this cycle.
- clr_req  in  1  one-cycle pulse; fill the whole map with clr_value.
- clr_value  in  4  fill code; sampled on clr_req.
- clr_busy  out  1  high from accepted clr_req until clear completes.
- mem_addr  out  9  single-port tile RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  4  RAM write data.
- mem_rdata  in  4  RAM read data; synchronous, valid one clock after address.
- tile_code  out  4  tile code for the tile containing the current pixel.

Function
REQ-003 SHALL grant the RAM port to one agent per clock, priority: display fetch > clear > writer.
REQ-004 SHALL issue a display fetch (mem_we=0) in the cycle where p_tick=1, pixel_x<640, pixel_x[4:0]=30 and (pixel_x>>5)+1 < TILE_COLS, using col=(pixel_x>>5)+1 and row=pixel_y>>5.
REQ-005 SHALL issue a display fetch in the cycle where p_tick=1 and pixel_x=798, using col=0 and row=ny>>5, where ny=0 if pixel_y=524 and ny=pixel_y+1 otherwise; it SHALL skip the fetch when ny is in 480..524.
REQ-006 SHALL compute the address as row*TILE_COLS+col, with no overflow for any legal row and col (maximum 299).
REQ-007 SHALL capture mem_rdata into a next-tile register exactly one clock after a display fetch.
REQ-008 SHALL load tile_code from the next-tile register on the clock edge where p_tick=1 and (pixel_x[4:0]=31 with pixel_x<639, or pixel_x=799); tile_code SHALL otherwise hold.
REQ-009 SHALL implement a clear FSM with states IDLE, WAIT_VB, CLEAR:
- IDLE: on clr_req, latch clr_value, zero the clear pointer, set clr_busy, go to WAIT_VB.
- WAIT_VB: go to CLEAR when pixel_y>=480.
- CLEAR: when pixel_y>=480 and there is no display fetch, write clr_value to the pointer address and increment the pointer. If pixel_y<480, return to WAIT_VB with the pointer kept. After writing address 299, go to IDLE and drop clr_busy the next cycle.
REQ-010 SHALL ignore clr_req while clr_busy=1.
REQ-011 SHALL perform a writer write only in a cycle with no display fetch and no clear write; that cycle SHALL drive mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data and wr_ack=1.
REQ-012 SHALL NOT ack a writer while the FSM is in CLEAR; the writer MAY be acked in WAIT_VB.
REQ-013 SHALL treat a wr_addr >299 as acked without asserting mem_we.
REQ-014 SHALL drive mem_we=0, mem_wdata=0 and mem_addr=0 on idle cycles.
REQ-015 SHALL assert wr_ack for at most one cycle per write; if wr_req stays high after an ack, that is a new request.

Reset
REQ-016 SHALL, while reset=1 at a clock edge, set:
- FSM to IDLE, clear pointer to 0, clr_busy=0.
- tile_code=0 and the next-tile register=0.
- wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 SHALL abandon an in-progress clear on reset; no further clear writes follow.

Verification
REQ-018 SHALL cover these directed scenarios:
- Display fetch: p_tick=1, pixel_x=30, pixel_y=64 -> mem_addr=41, mem_we=0. Next clock mem_rdata=5. At pixel_x=31 with p_tick=1 -> tile_code=5 after the edge.
- End-of-line prefetch: pixel_x=798, pixel_y=524, p_tick=1 -> mem_addr=0. At pixel_y=479 -> no fetch.
- Write vs fetch: wr_req=1, wr_addr=7, wr_data=3 held. In a display-fetch cycle -> wr_ack=0. Next free cycle -> mem_we=1, mem_addr=7, wr_ack=1.
- Clear: clr_req=1, clr_value=9 during active video -> clr_busy=1, no writes until pixel_y=480. Then 300 writes of 9 to addresses 0..299. clr_busy falls; a pending writer is held off until then.
- Clear straddling vblank: clr_req at pixel_y=524 -> writes stop when pixel_y wraps to 0 and resume at the same pointer at the next pixel_y=480.
- Reset mid-clear: reset=1 after 100 clear writes -> next cycle clr_busy=0, mem_we=0, tile_code=0.
